// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone-classic GPIO peripheral with per-bit direction,
// synchronised input sampling and edge-detect interrupt.
//
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wb_adr_i[4:2]          register select (0 IN, 1 OUT, 2 DIR, 3 RISE_EN,
//                          4 FALL_EN, 5 STATUS (W1C), 6/7 unmapped)
//   wb_dat_i, wb_sel_i     write data and byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i  bus control
//   wb_dat_o, wb_ack_o     registered read data, one-cycle acknowledge
//   gpio_i                 asynchronous pad inputs
//   gpio_o, gpio_oe_o      pad output data and output enables
//   irq_o                  high while any STATUS bit is set
module wb_gpio_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic             r_ack;
  logic [31:0]      r_dat;

  logic             w_req;
  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_sel;
  logic [31:0]      w_bmask;
  logic [WIDTH-1:0] w_wmask;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Gating the request with the ack gives one access per ack, so a held
  // strobe is acknowledged every second cycle.
  assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr    = w_req & wb_we_i;
  assign w_rd    = w_req & ~wb_we_i;
  assign w_sel   = wb_adr_i[4:2];
  assign w_bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                    {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wmask = w_bmask[WIDTH-1:0];
  assign w_wdata = wb_dat_i[WIDTH-1:0];

  // Byte-address LSBs and data bits above WIDTH carry no information.
  assign w_unused = ^{wb_adr_i[1:0], wb_dat_i, w_bmask};

  assign w_in   = r_sync[SYNC_STAGES-1];
  assign w_rise = w_in & ~r_prev & r_rise_en;
  assign w_fall = ~w_in & r_prev & r_fall_en;
  assign w_clr  = (w_wr && (w_sel == 3'd5)) ? (w_wdata & w_wmask) : '0;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata[WIDTH-1:0] = w_in;
      3'd1:    w_rdata[WIDTH-1:0] = r_out;
      3'd2:    w_rdata[WIDTH-1:0] = r_dir;
      3'd3:    w_rdata[WIDTH-1:0] = r_rise_en;
      3'd4:    w_rdata[WIDTH-1:0] = r_fall_en;
      3'd5:    w_rdata[WIDTH-1:0] = r_status;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd) r_dat <= w_rdata;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (w_sel)
        3'd1:    r_out     <= (r_out & ~w_wmask) | (w_wdata & w_wmask);
        3'd2:    r_dir     <= (r_dir & ~w_wmask) | (w_wdata & w_wmask);
        3'd3:    r_rise_en <= (r_rise_en & ~w_wmask) | (w_wdata & w_wmask);
        3'd4:    r_fall_en <= (r_fall_en & ~w_wmask) | (w_wdata & w_wmask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev   <= '0;
      r_status <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev   <= w_in;
      // New edges are OR-ed in after the clear so a simultaneous set wins.
      r_status <= (r_status & ~w_clr) | w_rise | w_fall;
    end
  end

  assign wb_dat_o  = r_dat;
  assign wb_ack_o  = r_ack;
  assign gpio_o    = r_out;
  assign gpio_oe_o = r_dir;
  assign irq_o     = |r_status;

endmodule

// File: tb/tb_wb_gpio_irq.sv
module tb_wb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] dat_o;
  logic        ack;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out, gpio_oe;
  logic        irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] rd;
  int unsigned acks;

  always #5 clk = ~clk;

  wb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .gpio_i    (gpio_in),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single access issued just after an edge; ack must appear on the next
  // edge and be gone one edge later.
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    tick();
    chk("ack_high", 32'(ack), 32'd1);
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk("ack_low", 32'(ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; adr = '0; dat_i = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; gpio_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state and all eight word addresses read zero
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_out", 32'(gpio_out), 32'h0);
    for (int unsigned i = 0; i < 8; i++) begin
      bus(1'b0, 5'(i * 4), 32'h0, 4'hF, rd);
      chk("rst_read", rd, 32'h0);
    end

    // Direction/output writes with byte enables
    bus(1'b1, 5'h08, 32'h0000_00FF, 4'b0001, rd);
    chk("dir_oe", 32'(gpio_oe), 32'hFF);
    bus(1'b1, 5'h04, 32'h0000_00A5, 4'b1111, rd);
    chk("out_a5", 32'(gpio_out), 32'hA5);
    bus(1'b1, 5'h04, 32'hFFFF_FF00, 4'b0010, rd);
    chk("out_sel", 32'(gpio_out), 32'hA5);
    bus(1'b0, 5'h04, 32'h0, 4'hF, rd);
    chk("out_rd", rd, 32'h0000_00A5);
    bus(1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF, rd);
    bus(1'b0, 5'h00, 32'h0, 4'hF, rd);
    chk("in_ro", rd, 32'h0);
    bus(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, rd);
    bus(1'b0, 5'h18, 32'h0, 4'hF, rd);
    chk("unmapped", rd, 32'h0);

    // Held strobe: acks on alternate cycles
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h04; acks = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      if (ack) acks++;
    end
    chk("held_acks", 32'(acks), 32'd2);
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Rising edge detect and latency
    bus(1'b1, 5'h0C, 32'h0000_0001, 4'hF, rd);
    gpio_in[0] = 1'b1;
    tick();
    chk("rise_lat1", 32'(irq), 32'd0);
    tick();
    chk("rise_lat2", 32'(irq), 32'd0);
    tick();
    chk("rise_irq", 32'(irq), 32'd1);
    bus(1'b0, 5'h14, 32'h0, 4'hF, rd);
    chk("rise_status", rd, 32'h0000_0001);
    bus(1'b0, 5'h00, 32'h0, 4'hF, rd);
    chk("in_rd", rd, 32'h0000_0001);

    // Clear, then falling edge with FALL_EN off sets nothing
    bus(1'b1, 5'h14, 32'h0000_0001, 4'b0001, rd);
    chk("clr_irq", 32'(irq), 32'd0);
    gpio_in[0] = 1'b0;
    repeat (4) tick();
    chk("fall_off_irq", 32'(irq), 32'd0);
    bus(1'b0, 5'h14, 32'h0, 4'hF, rd);
    chk("fall_off_st", rd, 32'h0);

    // Rising edge lands on the clearing edge: set wins
    gpio_in[0] = 1'b1;
    tick(); tick();
    bus(1'b1, 5'h14, 32'h0000_0001, 4'b0001, rd);
    chk("setwin_irq", 32'(irq), 32'd1);
    bus(1'b0, 5'h14, 32'h0, 4'hF, rd);
    chk("setwin_st", rd, 32'h0000_0001);

    // One-cycle glitch on bit 7 with FALL_EN
    bus(1'b1, 5'h10, 32'h0000_0080, 4'hF, rd);
    gpio_in[7] = 1'b1;
    tick();
    gpio_in[7] = 1'b0;
    repeat (3) tick();
    bus(1'b0, 5'h14, 32'h0, 4'hF, rd);
    chk("glitch_st", rd, 32'h0000_0081);
    bus(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, rd);
    bus(1'b0, 5'h14, 32'h0, 4'hF, rd);
    chk("w1c_all", rd, 32'h0);
    chk("w1c_irq", 32'(irq), 32'd0);
    bus(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, rd);
    bus(1'b0, 5'h08, 32'h0, 4'hF, rd);
    chk("dir_upper", rd, 32'h0000_00FF);

    // Enabling while input already high does not set STATUS
    bus(1'b1, 5'h0C, 32'h0, 4'hF, rd);
    bus(1'b1, 5'h0C, 32'h0000_0001, 4'hF, rd);
    repeat (3) tick();
    bus(1'b0, 5'h14, 32'h0, 4'hF, rd);
    chk("en_high_st", rd, 32'h0);

    // Reset mid-read with outputs and irq active
    bus(1'b1, 5'h04, 32'h0000_003C, 4'hF, rd);
    gpio_in[0] = 1'b0;
    repeat (3) tick();
    gpio_in[0] = 1'b1;
    repeat (3) tick();
    chk("pre_irq", 32'(irq), 32'd1);
    chk("pre_out", 32'(gpio_out), 32'h3C);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h04;
    tick();
    chk("pre_ack", 32'(ack), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_out", 32'(gpio_out), 32'h0);
    chk("arst_oe", 32'(gpio_oe), 32'h0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_dat", dat_o, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    tick();
    bus(1'b0, 5'h04, 32'h0, 4'hF, rd);
    chk("post_out", rd, 32'h0);
    chk("post_oe", 32'(gpio_oe), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
Parametrised Wishbone-classic GPIO peripheral for the picorv32 Wishbone SoC family, exposing WIDTH bidirectional pins through the board top level (e.g. LED/IO banks).
Provides:
- per-bit direction and output data;
- double-flop synchronised input sampling;
- per-bit rising/falling edge detection with a write-1-to-clear status register and a single level interrupt.
Sits on the SoC Wishbone bus beside the UART; pads are driven by the board top from gpio_o/gpio_oe_o.

Parameters:
WIDTH, 8, number of GPIO bits (1..32); register bits at and above WIDTH read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
wb_clk_i  input  1  Wishbone/system clock
wb_rst_n_i  input  1  asynchronous reset, active-low
wb_adr_i  input  5  byte address; bits [4:2] select the register, [1:0] ignored
wb_dat_i  input  32  write data
wb_sel_i  input  4  byte enables for writes
wb_we_i  input  1  write enable
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_dat_o  output  32  registered read data
wb_ack_o  output  1  acknowledge
gpio_i  input  WIDTH  asynchronous pad inputs
gpio_o  output  WIDTH  output data (OUT register)
gpio_oe_o  output  WIDTH  output enables (DIR register, 1 = drive)
irq_o  output  1  interrupt, high while any STATUS bit is set

Behaviour:
Register map (word index = wb_adr_i[4:2]):
- 0 IN: read-only, synchronised input; writes ignored.
- 1 OUT: read/write.
- 2 DIR: read/write.
- 3 RISE_EN: read/write.
- 4 FALL_EN: read/write.
- 5 STATUS: read; write-1-to-clear.
- 6, 7 unmapped: read 0, writes ignored, still acked.

Reset (asynchronous on wb_rst_n_i low, release synchronous to the clock via the same flops):
- OUT, DIR, RISE_EN, FALL_EN, STATUS = 0.
- Synchroniser and previous-sample flops = 0.
- wb_ack_o = 0, wb_dat_o = 0, gpio_o = 0, gpio_oe_o = 0, irq_o = 0.

Bus handshake:
- A request is wb_cyc_i & wb_stb_i & ~wb_ack_o.
- wb_ack_o asserts on the clock edge after the request and stays high exactly one cycle.
- Held stb produces an ack every second cycle; one access per ack.
- On a read, wb_dat_o is loaded on the same edge that raises ack and holds until the next read.
- On a write, the register updates on the same edge that raises ack.
- Writes honour wb_sel_i per byte; unselected bytes are unchanged. For STATUS, only selected bytes clear.
- Reset mid-transaction aborts it: ack drops immediately (async), and no register update occurs.

Input path:
- gpio_i passes through a SYNC_STAGES flop chain; IN = last stage.
- prev = IN delayed one cycle.
- rise = IN & ~prev & RISE_EN; fall = ~IN & prev & FALL_EN.
- Latency: a gpio_i change stable before edge k appears in IN after edge k+SYNC_STAGES-1. The STATUS bit and irq_o are set on the following edge.

STATUS:
- next = (STATUS & ~clear_mask) | rise | fall.
- If set and clear hit the same bit in the same cycle, set wins.
- irq_o = |STATUS (register-driven, no combinational path from the bus).
- Enabling RISE_EN while the input is already high does not set STATUS; only a transition after enable does.

Outputs:
- gpio_o = OUT and gpio_oe_o = DIR directly.
- IN reflects the pad regardless of DIR, so a driven output loops back.

Test Plan:
1. Reset, then read all 8 word addresses -> all read 0x00000000; irq_o=0, gpio_oe_o=0; each ack one cycle wide and one cycle after stb.
2. Write DIR=0x000000FF with sel=4'b0001, then OUT=0xA5 -> gpio_oe_o=8'hFF, gpio_o=8'hA5. Write OUT=0xFFFF_FF00 with sel=4'b0010 -> gpio_o stays 0xA5. Readback of OUT returns 0x000000A5.
3. RISE_EN=0x01; toggle gpio_i[0] 0->1 at cycle t -> IN[0]=1 readable after SYNC_STAGES edges; STATUS=0x01 and irq_o=1 one edge later. Falling edge sets nothing (FALL_EN=0).
4. Write STATUS=0x01 -> STATUS=0, irq_o=0 on the ack edge. Repeat with a new rising edge landing on the clear edge -> STATUS stays 0x01 (set wins).
5. FALL_EN=0x80, WIDTH=8; drive a 1-cycle glitch on gpio_i[7] -> STATUS[7] set after the glitch passes the synchroniser. Write 0xFFFFFFFF to STATUS -> bits [31:8] read 0.
6. Assert wb_rst_n_i low for 3 cycles while stb is held mid-read with OUT=0x3C, DIR=0xFF -> ack, gpio_o, gpio_oe_o, irq_o drop asynchronously to 0. After release, the next request is acked normally.
